// File: rtl/maze_pkg.sv
// Shared types and constants for the maze motion executor.
// Contents:
//   SPD_W       - width of the forward speed word
//   nav_state_t - executor state: idle, heading change, or one of the three
//                 move phases (ramp up, normal decel, brake)
package maze_pkg;

  localparam int SPD_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    HDG,
    RAMP_UP,
    DECEL,
    BRAKE
  } nav_state_t;

endpackage

// File: rtl/maze_navigate_if.sv
// Command/sensor/speed bundle between the maze solver, the sensors and the
// motion executor.
// Signals:
//   strt_hdng, strt_mv  - one-cycle command pulses from the solver
//   stp_lft, stp_rght   - which side opening ends a move
//   hdng_rdy            - new heading sample strobe (speed update tick)
//   at_hdng             - heading error within tolerance
//   lft_opn, rght_opn   - side walls absent
//   frwrd_opn           - no wall ahead
//   mv_cmplt            - one-cycle pulse: command finished
//   moving              - a command is executing
//   en_fusion           - speed high enough for sensor fusion
//   frwrd_spd           - forward speed to the PID/motor stage
// Modports: master drives commands and sensors, slave is the executor.
interface maze_navigate_if;
  import maze_pkg::*;

  logic             strt_hdng;
  logic             strt_mv;
  logic             stp_lft;
  logic             stp_rght;
  logic             hdng_rdy;
  logic             at_hdng;
  logic             lft_opn;
  logic             rght_opn;
  logic             frwrd_opn;
  logic             mv_cmplt;
  logic             moving;
  logic             en_fusion;
  logic [SPD_W-1:0] frwrd_spd;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    input  mv_cmplt, moving, en_fusion, frwrd_spd
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    output mv_cmplt, moving, en_fusion, frwrd_spd
  );

endinterface

// File: rtl/maze_navigate_rise_det.sv
// 1-bit synchronous rising-edge detector.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears the history bit)
//   din  - level input
//   rise - high while din is 1 and was 0 on the previous cycle
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/maze_navigate.sv
// Motion executor downstream of the maze solver. A heading command waits
// for the heading controller to settle; a move command ramps the forward
// speed up from MIN_FRWRD and then decelerates to zero once a wall appears
// ahead (hard brake) or the selected side opening appears (normal decel).
// Every finished command returns a one-cycle mv_cmplt.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   nav - maze_navigate_if.slave (commands, sensors, status, speed)
module maze_navigate
  import maze_pkg::*;
#(
  parameter logic [SPD_W-1:0] SPD_INC   = 11'h018,
  parameter logic [SPD_W-1:0] MIN_FRWRD = 11'h0D0,
  parameter logic [SPD_W-1:0] MAX_FRWRD = 11'h2A0
) (
  input  logic           clk,
  input  logic           rst,
  maze_navigate_if.slave nav
);

  localparam logic [SPD_W-1:0] DEC_STEP = SPD_INC << 1;
  localparam logic [SPD_W-1:0] BRK_STEP = SPD_INC << 2;

  nav_state_t       state, state_nxt;
  logic [SPD_W-1:0] spd, spd_nxt;
  logic [SPD_W-1:0] step;
  logic             cmplt, cmplt_nxt;
  logic             lft_rise, rght_rise;

  // Ramp step is added one bit wider so overflow can never wrap past the cap.
  function automatic logic [SPD_W-1:0] ramp_sat(input logic [SPD_W-1:0] s);
    logic [SPD_W:0] sum;
    sum = {1'b0, s} + {1'b0, SPD_INC};
    if (sum > {1'b0, MAX_FRWRD}) return MAX_FRWRD;
    return sum[SPD_W-1:0];
  endfunction

  rise_det u_lft_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (nav.lft_opn),
    .rise (lft_rise)
  );

  rise_det u_rght_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (nav.rght_opn),
    .rise (rght_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      spd   <= '0;
      cmplt <= 1'b0;
    end else begin
      state <= state_nxt;
      spd   <= spd_nxt;
      cmplt <= cmplt_nxt;
    end
  end

  assign step = (state == BRAKE) ? BRK_STEP : DEC_STEP;

  always_comb begin
    state_nxt = state;
    spd_nxt   = spd;
    cmplt_nxt = 1'b0;
    case (state)
      IDLE: begin
        spd_nxt = '0;
        // Heading wins a same-cycle collision; the move request is dropped.
        if (nav.strt_hdng) begin
          state_nxt = HDG;
        end else if (nav.strt_mv) begin
          state_nxt = RAMP_UP;
          spd_nxt   = MIN_FRWRD;
        end
      end
      HDG: begin
        spd_nxt = '0;
        if (nav.at_hdng) begin
          state_nxt = IDLE;
          cmplt_nxt = 1'b1;
        end
      end
      RAMP_UP: begin
        if (!nav.frwrd_opn) begin
          state_nxt = BRAKE;
        end else if ((nav.stp_lft & lft_rise) | (nav.stp_rght & rght_rise)) begin
          state_nxt = DECEL;
        end else if (nav.hdng_rdy) begin
          spd_nxt = ramp_sat(spd);
        end
      end
      DECEL, BRAKE: begin
        if (state == DECEL && !nav.frwrd_opn) begin
          state_nxt = BRAKE;
        end else if (nav.hdng_rdy) begin
          // Compare before subtracting so the speed never wraps below zero.
          if (spd <= step) begin
            spd_nxt   = '0;
            state_nxt = IDLE;
            cmplt_nxt = 1'b1;
          end else begin
            spd_nxt = spd - step;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        spd_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    nav.moving    = (state != IDLE);
    nav.en_fusion = (spd > (MAX_FRWRD >> 1));
    nav.frwrd_spd = spd;
    nav.mv_cmplt  = cmplt;
  end

endmodule

// File: tb/tb_maze_navigate.sv
// Self-checking bench for maze_navigate: directed scenarios plus a random
// soak, all compared every cycle against a behavioural model of the
// command/speed rules.
module tb_maze_navigate;

  logic clk;
  logic rst;

  maze_navigate_if nav ();

  maze_navigate dut (
    .clk (clk),
    .rst (rst),
    .nav (nav)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int INC = 'h018;
  localparam int MINS = 'h0D0;
  localparam int MAXS = 'h2A0;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: busy flag, command kind, and the current decel step
  // (0 while still accelerating).
  int m_spd = 0;
  bit m_busy = 0;
  bit m_move = 0;
  int m_step = 0;
  bit m_cmplt = 0;
  bit m_lprev = 0;
  bit m_rprev = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit lr, rr;
    lr = nav.lft_opn && !m_lprev;
    rr = nav.rght_opn && !m_rprev;
    m_cmplt = 0;
    if (rst) begin
      m_spd = 0; m_busy = 0; m_move = 0; m_step = 0;
    end else if (!m_busy) begin
      if (nav.strt_hdng) begin
        m_busy = 1; m_move = 0;
      end else if (nav.strt_mv) begin
        m_busy = 1; m_move = 1; m_step = 0; m_spd = MINS;
      end
    end else if (!m_move) begin
      if (nav.at_hdng) begin m_busy = 0; m_cmplt = 1; end
    end else if (m_step == 0) begin
      if (!nav.frwrd_opn) m_step = 4 * INC;
      else if ((nav.stp_lft && lr) || (nav.stp_rght && rr)) m_step = 2 * INC;
      else if (nav.hdng_rdy) m_spd = (m_spd + INC > MAXS) ? MAXS : m_spd + INC;
    end else begin
      if (m_step == 2 * INC && !nav.frwrd_opn) m_step = 4 * INC;
      else if (nav.hdng_rdy) begin
        if (m_spd <= m_step) begin m_spd = 0; m_busy = 0; m_cmplt = 1; end
        else m_spd -= m_step;
      end
    end
    m_lprev = rst ? 1'b0 : nav.lft_opn;
    m_rprev = rst ? 1'b0 : nav.rght_opn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("spd", int'(nav.frwrd_spd), m_spd);
    chk("moving", int'(nav.moving), int'(m_busy));
    chk("cmplt", int'(nav.mv_cmplt), int'(m_cmplt));
    chk("fusion", int'(nav.en_fusion), int'(m_spd > MAXS / 2));
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      nav.hdng_rdy = 1'b1;
      tick();
    end
    nav.hdng_rdy = 1'b0;
  endtask

  task automatic pulse_mv();
    nav.strt_mv = 1'b1;
    tick();
    nav.strt_mv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    nav.strt_hdng = 0; nav.strt_mv = 0; nav.stp_lft = 0; nav.stp_rght = 0;
    nav.hdng_rdy = 0; nav.at_hdng = 0; nav.lft_opn = 0; nav.rght_opn = 0;
    nav.frwrd_opn = 1;
    do_reset();
    chk("rst_spd", int'(nav.frwrd_spd), 0);
    chk("rst_moving", int'(nav.moving), 0);

    // Reset in the middle of a move, then a clean restart
    pulse_mv();
    strobe(5);
    do_reset();
    chk("midrst_spd", int'(nav.frwrd_spd), 0);
    chk("midrst_moving", int'(nav.moving), 0);
    chk("midrst_cmplt", int'(nav.mv_cmplt), 0);
    pulse_mv();
    chk("restart_spd", int'(nav.frwrd_spd), MINS);
    do_reset();

    // Heading change completing ten cycles later
    nav.strt_hdng = 1; tick(); nav.strt_hdng = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("hdg_wait_moving", int'(nav.moving), 1);
    nav.at_hdng = 1; tick(); nav.at_hdng = 0;
    chk("hdg_cmplt", int'(nav.mv_cmplt), 1);
    chk("hdg_moving_low", int'(nav.moving), 0);
    tick();
    chk("hdg_cmplt_one", int'(nav.mv_cmplt), 0);

    // Ramp to saturation, ignored restart, then left side-stop decel
    pulse_mv();
    chk("ramp_start", int'(nav.frwrd_spd), 'h0D0);
    strobe(1);
    chk("ramp_1", int'(nav.frwrd_spd), 'h0E8);
    strobe(19);
    chk("ramp_20", int'(nav.frwrd_spd), 'h2A0);
    strobe(3);
    chk("ramp_hold", int'(nav.frwrd_spd), 'h2A0);
    chk("ramp_fusion", int'(nav.en_fusion), 1);
    pulse_mv();
    chk("no_reload", int'(nav.frwrd_spd), 'h2A0);
    nav.stp_lft = 1;
    nav.rght_opn = 1; tick();
    nav.lft_opn = 1; tick();
    strobe(13);
    chk("decel_13", int'(nav.frwrd_spd), 'h030);
    strobe(1);
    chk("decel_end_spd", int'(nav.frwrd_spd), 0);
    chk("decel_cmplt", int'(nav.mv_cmplt), 1);
    nav.stp_lft = 0; nav.lft_opn = 0; nav.rght_opn = 0; tick();

    // Brake from full speed
    pulse_mv();
    strobe(20);
    nav.frwrd_opn = 0; tick();
    strobe(6);
    chk("brake_6", int'(nav.frwrd_spd), 'h060);
    strobe(1);
    chk("brake_cmplt", int'(nav.mv_cmplt), 1);
    nav.frwrd_opn = 1; tick();

    // Decel switching into brake
    pulse_mv();
    strobe(20);
    nav.stp_rght = 1; nav.rght_opn = 1; tick();
    strobe(1);
    chk("d2b_decel", int'(nav.frwrd_spd), 'h270);
    nav.frwrd_opn = 0; tick();
    strobe(1);
    chk("d2b_brake", int'(nav.frwrd_spd), 'h210);
    nav.frwrd_opn = 1; nav.stp_rght = 0; nav.rght_opn = 0;
    do_reset();

    // Simultaneous commands: heading wins
    nav.strt_hdng = 1; nav.strt_mv = 1; tick();
    nav.strt_hdng = 0; nav.strt_mv = 0;
    chk("both_spd", int'(nav.frwrd_spd), 0);
    chk("both_moving", int'(nav.moving), 1);
    nav.at_hdng = 1; tick(); nav.at_hdng = 0; tick();

    // Opening already present at move start is not an edge
    nav.lft_opn = 1; nav.stp_lft = 1;
    pulse_mv();
    strobe(3);
    chk("pre_open_ramp", int'(nav.frwrd_spd), MINS + 3 * INC);
    nav.lft_opn = 0; tick();
    nav.lft_opn = 1; tick();
    strobe(1);
    chk("pre_open_decel", int'(nav.frwrd_spd), MINS + INC);
    nav.lft_opn = 0; nav.stp_lft = 0;
    do_reset();

    // Random soak
    for (int i = 0; i < 4000; i++) begin
      nav.strt_hdng = ($urandom_range(0, 15) == 0);
      nav.strt_mv   = ($urandom_range(0, 5) == 0);
      nav.hdng_rdy  = ($urandom_range(0, 2) == 0);
      nav.at_hdng   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) nav.lft_opn = ~nav.lft_opn;
      if ($urandom_range(0, 11) == 0) nav.rght_opn = ~nav.rght_opn;
      nav.frwrd_opn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) begin
        nav.stp_lft  = 1'($urandom_range(0, 1));
        nav.stp_rght = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
